// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the arbiter FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  localparam logic [3:0] HPROT_INSTR   = 4'b0010;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_LERR
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker: round-robin on contention, or m0-wins when fixed_prio is set.
module rr_arb2 (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  logic       update,
  output logic [1:0] grant,
  output logic       ptr
);

  // ptr holds the last granted port; reset to m1 so m0 wins the first contention
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (fixed_prio || ptr) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ptr <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      ptr <= grant[1];
    end
  end

endmodule

// File: rtl/ahb_sram_arbiter.sv
// Two-port req/done front end sharing one AHB-Lite SRAM slave, one single-beat
// non-pipelined transfer at a time, with window, alignment and timeout checks.
module ahb_sram_arbiter
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
  parameter int unsigned SIZE       = 256,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        hmaster
);

  localparam int unsigned TW     = $clog2(TIMEOUT);
  // 33-bit bounds so BASE_ADDR + SIZE*4 cannot wrap past 4 GiB
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(SIZE) * 33'd4;

  arb_state_e    state, state_nxt;
  logic [1:0]    req, grant;
  logic          arb_upd, sel_write, sel_legal;
  logic          fire_done, fire_err, cap_rdata;
  logic [31:0]   sel_addr, sel_wdata, wdata_q;
  logic [TW-1:0] to_cnt;
  logic          arb_ptr_unused;

  assign req = {m1_req, m0_req};

  rr_arb2 u_arb (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .req        (req),
    .fixed_prio (FIXED_PRIO),
    .update     (arb_upd),
    .grant      (grant),
    .ptr        (arb_ptr_unused)
  );

  assign sel_addr  = grant[1] ? m1_addr  : m0_addr;
  assign sel_wdata = grant[1] ? m1_wdata : m0_wdata;
  assign sel_write = grant[1] ? m1_write : m0_write;
  assign sel_legal = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI) &&
                     (sel_addr[1:0] == 2'b00);

  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arb_upd   = 1'b0;
    fire_done = 1'b0;
    fire_err  = 1'b0;
    cap_rdata = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          arb_upd   = 1'b1;
          state_nxt = sel_legal ? ST_ADDR : ST_LERR;
        end
      end
      ST_ADDR: state_nxt = ST_DATA;
      ST_DATA: begin
        // HRESP during a wait state is only the first half of an ERROR response
        if (HREADY) begin
          fire_done = 1'b1;
          fire_err  = (HRESP == HRESP_ERROR);
          cap_rdata = !HWRITE;
          state_nxt = ST_IDLE;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          fire_done = 1'b1;
          fire_err  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_LERR: begin
        fire_done = 1'b1;
        fire_err  = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      HADDR    <= '0;
      HTRANS   <= HTRANS_IDLE;
      HWRITE   <= 1'b0;
      HPROT    <= '0;
      HWDATA   <= '0;
      hmaster  <= 1'b0;
      wdata_q  <= '0;
      to_cnt   <= '0;
    end else begin
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;

      if (arb_upd) begin
        m0_gnt  <= grant[0];
        m1_gnt  <= grant[1];
        hmaster <= grant[1];
        // Illegal requests are answered locally and never reach the bus
        if (sel_legal) begin
          HTRANS  <= HTRANS_NONSEQ;
          HADDR   <= sel_addr;
          HWRITE  <= sel_write;
          HPROT   <= grant[1] ? HPROT_DATA : HPROT_INSTR;
          wdata_q <= sel_wdata;
        end
      end

      if (state == ST_ADDR) begin
        HTRANS <= HTRANS_IDLE;
        HWDATA <= wdata_q;
        to_cnt <= '0;
      end else if (state == ST_DATA && !HREADY) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (fire_done) begin
        m0_done <= !hmaster;
        m1_done <= hmaster;
        m0_err  <= !hmaster && fire_err;
        m1_err  <= hmaster && fire_err;
      end
      if (cap_rdata) begin
        if (hmaster) m1_rdata <= HRDATA;
        else         m0_rdata <= HRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Directed bench for ahb_sram_arbiter: latency, arbitration, range/alignment, wait/error and timeout.
module tb_ahb_sram_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP, hmaster;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  logic        f_m0_gnt, f_m0_done, f_m0_err, f_m1_gnt, f_m1_done, f_m1_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_HADDR, f_HWDATA;
  logic [1:0]  f_HTRANS;
  logic        f_HWRITE, f_HMASTLOCK, f_hmaster;
  logic [2:0]  f_HSIZE, f_HBURST;
  logic [3:0]  f_HPROT;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahb_sram_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .hmaster(hmaster)
  );

  // Fixed-priority twin sees the same stimulus; only its grants are inspected
  ahb_sram_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(f_m0_gnt), .m0_done(f_m0_done), .m0_err(f_m0_err), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(f_m1_gnt), .m1_done(f_m1_done), .m1_err(f_m1_err), .m1_rdata(f_m1_rdata),
    .HADDR(f_HADDR), .HTRANS(f_HTRANS), .HWRITE(f_HWRITE), .HSIZE(f_HSIZE), .HBURST(f_HBURST),
    .HMASTLOCK(f_HMASTLOCK), .HPROT(f_HPROT), .HWDATA(f_HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .hmaster(f_hmaster)
  );

  // Requesters must hold req from gnt until done
  logic pend0 = 1'b0, pend1 = 1'b0;
  always @(posedge HCLK) begin
    if (!HRESETn) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (pend0 && !m0_done && !m0_req) $error("FAIL proto_m0: req dropped before done");
      if (pend1 && !m1_done && !m1_req) $error("FAIL proto_m1: req dropped before done");
      if (m0_gnt) pend0 <= 1'b1; else if (m0_done) pend0 <= 1'b0;
      if (m1_gnt) pend1 <= 1'b1; else if (m1_done) pend1 <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drop_all;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    tick;
    tick;
    total++;
    if (HTRANS !== 2'b00) begin bad++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
    total++;
    if ({HADDR, HWDATA} !== 64'h0) begin bad++; $display("FAIL reset_haddr_hwdata: got %h %h want 0 0", HADDR, HWDATA); end
    total++;
    if ({HWRITE, HPROT, hmaster} !== 6'b0) begin bad++; $display("FAIL reset_ctl: got %b%b%b want 000000", HWRITE, HPROT, hmaster); end
    total++;
    if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err} !== 6'b0) begin
      bad++; $display("FAIL reset_pulses: got %b want 000000", {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err});
    end
    total++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %h %h want 0 0", m0_rdata, m1_rdata); end
    total++;
    if ({HSIZE, HBURST, HMASTLOCK} !== 7'b010_000_0) begin bad++; $display("FAIL const_ctl: got %b %b %b want 010 000 0", HSIZE, HBURST, HMASTLOCK); end
    HRESETn = 1'b1;
    tick;
  endtask

  task automatic test_read_m1;
    HRDATA = 32'hDEADBEEF;
    m1_write = 1'b0; m1_addr = 32'h0010_0008; m1_req = 1'b1;
    tick;
    total++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin bad++; $display("FAIL rd_gnt: got m1=%b m0=%b want 1 0", m1_gnt, m0_gnt); end
    total++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h0010_0008 || HWRITE !== 1'b0) begin
      bad++; $display("FAIL rd_addr_phase: got %b %h %b want 10 00100008 0", HTRANS, HADDR, HWRITE);
    end
    total++;
    if (HPROT !== 4'b0011 || hmaster !== 1'b1) begin bad++; $display("FAIL rd_owner: got hprot=%b hmaster=%b want 0011 1", HPROT, hmaster); end
    tick;
    total++;
    if (HTRANS !== 2'b00 || m1_done !== 1'b0) begin bad++; $display("FAIL rd_data_phase: got %b done=%b want 00 0", HTRANS, m1_done); end
    tick;
    total++;
    if ({m1_done, m1_err, m0_done} !== 3'b100) begin bad++; $display("FAIL rd_done: got %b want 100", {m1_done, m1_err, m0_done}); end
    total++;
    if (m1_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata: got %h want deadbeef", m1_rdata); end
    drop_all;
    tick;
  endtask

  task automatic test_contention;
    int seq[$];
    int fp0, fp1;
    fp0 = 0; fp1 = 0;
    m0_write = 1'b0; m0_addr = 32'h0010_0040;
    m1_write = 1'b0; m1_addr = 32'h0010_0044;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (m0_gnt) seq.push_back(0);
      if (m1_gnt) seq.push_back(1);
      if (f_m0_gnt) fp0++;
      if (f_m1_gnt) fp1++;
    end
    total++;
    if (m1_done !== 1'b1) begin bad++; $display("FAIL rr_last_done: got %b want 1", m1_done); end
    drop_all;
    total++;
    if (seq.size() != 4) begin bad++; $display("FAIL rr_count: got %0d want 4", seq.size()); end
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
      total++;
      if (seq[i] != (i % 2)) begin bad++; $display("FAIL rr_order[%0d]: got m%0d want m%0d", i, seq[i], i % 2); end
    end
    total++;
    if (fp1 != 0 || fp0 != 4) begin bad++; $display("FAIL fixed_prio: got m0=%0d m1=%0d grants want 4 0", fp0, fp1); end
    tick;
  endtask

  task automatic test_write_last;
    m0_write = 1'b1; m0_addr = 32'h0010_03FC; m0_wdata = 32'h1234_5678; m0_req = 1'b1;
    tick;
    total++;
    if (m0_gnt !== 1'b1 || HTRANS !== 2'b10 || HWRITE !== 1'b1 || HADDR !== 32'h0010_03FC) begin
      bad++; $display("FAIL wr_addr_phase: got gnt=%b %b w=%b %h want 1 10 1 001003fc", m0_gnt, HTRANS, HWRITE, HADDR);
    end
    total++;
    if (HPROT !== 4'b0010 || hmaster !== 1'b0) begin bad++; $display("FAIL wr_owner: got %b %b want 0010 0", HPROT, hmaster); end
    tick;
    total++;
    if (HWDATA !== 32'h1234_5678 || HTRANS !== 2'b00) begin bad++; $display("FAIL wr_hwdata: got %h %b want 12345678 00", HWDATA, HTRANS); end
    tick;
    total++;
    if ({m0_done, m0_err} !== 2'b10) begin bad++; $display("FAIL wr_done: got %b want 10", {m0_done, m0_err}); end
    drop_all;
    tick;
  endtask

  task automatic test_illegal;
    logic [31:0] bad_addr [2];
    logic        seen_bus;
    bad_addr[0] = 32'h0010_0400;
    bad_addr[1] = 32'h0010_0002;
    for (int k = 0; k < 2; k++) begin
      seen_bus = 1'b0;
      m0_write = 1'b1; m0_addr = bad_addr[k]; m0_wdata = 32'hA5A5_A5A5; m0_req = 1'b1;
      tick;
      if (HTRANS !== 2'b00) seen_bus = 1'b1;
      total++;
      if (m0_gnt !== 1'b1) begin bad++; $display("FAIL ill_gnt[%0d]: got %b want 1", k, m0_gnt); end
      tick;
      if (HTRANS !== 2'b00) seen_bus = 1'b1;
      total++;
      if ({m0_done, m0_err} !== 2'b11) begin bad++; $display("FAIL ill_done[%0d]: got %b want 11", k, {m0_done, m0_err}); end
      drop_all;
      tick;
      if (HTRANS !== 2'b00) seen_bus = 1'b1;
      total++;
      if (seen_bus !== 1'b0) begin bad++; $display("FAIL ill_htrans[%0d]: got bus activity want none", k); end
    end
  endtask

  task automatic test_wait_error;
    m1_write = 1'b0; m1_addr = 32'h0010_0010; m1_req = 1'b1;
    tick;
    HREADY = 1'b0; HRESP = 1'b0;
    tick;
    tick;
    total++;
    if (m1_done !== 1'b0) begin bad++; $display("FAIL wt_early1: got done=%b want 0", m1_done); end
    tick;
    HRESP = 1'b1;
    tick;
    total++;
    if (m1_done !== 1'b0) begin bad++; $display("FAIL wt_resp_hready_low: got done=%b want 0", m1_done); end
    HREADY = 1'b1;
    tick;
    total++;
    if ({m1_done, m1_err} !== 2'b11) begin bad++; $display("FAIL wt_err_done: got %b want 11", {m1_done, m1_err}); end
    HRESP = 1'b0;
    drop_all;
    tick;
  endtask

  task automatic test_timeout;
    logic early;
    early = 1'b0;
    m0_write = 1'b0; m0_addr = 32'h0010_0080; m0_req = 1'b1;
    tick;
    HREADY = 1'b0;
    tick;
    for (int e = 3; e <= 17; e++) begin
      tick;
      if (m0_done !== 1'b0) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin bad++; $display("FAIL to_early: got done before cycle 16 want none"); end
    tick;
    total++;
    if ({m0_done, m0_err} !== 2'b11) begin bad++; $display("FAIL to_done: got %b want 11", {m0_done, m0_err}); end
    HREADY = 1'b1;
    drop_all;
    tick;
    HRDATA = 32'hCAFEF00D;
    m0_write = 1'b0; m0_addr = 32'h0010_0100; m0_req = 1'b1;
    tick;
    total++;
    if (m0_gnt !== 1'b1 || HTRANS !== 2'b10) begin bad++; $display("FAIL to_recover_gnt: got %b %b want 1 10", m0_gnt, HTRANS); end
    tick;
    tick;
    total++;
    if ({m0_done, m0_err} !== 2'b10 || m0_rdata !== 32'hCAFEF00D) begin
      bad++; $display("FAIL to_recover_done: got %b %h want 10 cafef00d", {m0_done, m0_err}, m0_rdata);
    end
    drop_all;
    tick;
  endtask

  task automatic test_reset_mid;
    logic stray;
    stray = 1'b0;
    m1_write = 1'b0; m1_addr = 32'h0010_0020; m1_req = 1'b1;
    tick;
    HREADY = 1'b0;
    tick;
    tick;
    HRESETn = 1'b0;
    drop_all;
    HREADY = 1'b1;
    tick;
    total++;
    if (HTRANS !== 2'b00 || m1_done !== 1'b0) begin bad++; $display("FAIL rst_mid: got %b done=%b want 00 0", HTRANS, m1_done); end
    tick;
    if (m1_done !== 1'b0 || m0_done !== 1'b0) stray = 1'b1;
    m0_write = 1'b0; m0_addr = 32'h0010_0030;
    m1_write = 1'b0; m1_addr = 32'h0010_0034;
    HRESETn = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    tick;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || HADDR !== 32'h0010_0030) begin
      bad++; $display("FAIL rst_first_gnt: got m0=%b m1=%b %h want 1 0 00100030", m0_gnt, m1_gnt, HADDR);
    end
    tick;
    if (m1_done !== 1'b0) stray = 1'b1;
    tick;
    total++;
    if (m0_done !== 1'b1 || stray !== 1'b0) begin bad++; $display("FAIL rst_after: got m0_done=%b stray=%b want 1 0", m0_done, stray); end
    drop_all;
    tick;
  endtask

  initial begin
    HRESETn = 1'b0;
    m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    test_reset;
    test_read_m1;
    test_contention;
    test_write_last;
    test_illegal;
    test_wait_error;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
